// File: rtl/nn_conv_sched.sv
// nn_conv_sched: shares one 3x3 conv engine across a fixed two-layer
// job table (J0..J8). Layer-1 passes (J0-J2) convolve the 12x12 input
// into the 10x10 maps o1..o3. Layer-2 passes (J3-J8) convolve those maps
// into the 8x8 slices of out1/out2.
// Optional build macro NN_SCHED_SKIP_DUP_EN: J8 (identical to J7) is not
// issued, and the J7 result is written to both out1 and out2.
module nn_conv_sched #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [287:0] in,
  input  logic [17:0]  filter1,
  input  logic [17:0]  filter2,
  input  logic [17:0]  filter3,
  input  logic [17:0]  filter4,
  output logic         eng_start,
  output logic         eng_layer,
  output logic [287:0] eng_img,
  output logic [17:0]  eng_filt,
  input  logic         eng_done,
  input  logic [199:0] eng_res1,
  input  logic [127:0] eng_res2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [383:0] out1,
  output logic [383:0] out2,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

`ifdef NN_SCHED_SKIP_DUP_EN
  localparam logic [3:0] LAST_JOB = 4'd7;
`else
  localparam logic [3:0] LAST_JOB = 4'd8;
`endif
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t         state, state_nxt;
  logic [3:0]     job;
  logic [7:0]     wait_cnt;
  logic [287:0]   img_q;
  logic [17:0]    f1_q, f2_q, f3_q, f4_q;
  logic [199:0]   o1, o2, o3;
  logic           accept, tmo_hit, job_end, timed_out;
  logic [199:0]   res1;
  logic [127:0]   res2;

  // A job ends on eng_done or on its last allowed WAIT cycle; done wins a tie.
  assign accept    = (state == IDLE) && in_valid;
  assign tmo_hit   = (wait_cnt == TO_LAST);
  assign job_end   = (state == WAIT) && (eng_done || tmo_hit);
  assign timed_out = (state == WAIT) && tmo_hit && !eng_done;
  // A timed-out job stores zero in its slot.
  assign res1      = eng_done ? eng_res1 : '0;
  assign res2      = eng_done ? eng_res2 : '0;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    eng_start = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (job_end) state_nxt = (job == LAST_JOB) ? OUT : ISSUE;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Engine command decode from the job table. The operands are registers
  // that do not change until the job's capture edge, so the command is stable
  // from ISSUE through WAIT.
  always_comb begin
    eng_layer = 1'b0;
    eng_img   = img_q;
    eng_filt  = f1_q;
    case (job)
      4'd0: eng_filt = f1_q;
      4'd1: eng_filt = f3_q;
      4'd2: eng_filt = f2_q;
      4'd3: begin eng_layer = 1'b1; eng_img = {88'b0, o1}; eng_filt = f1_q; end
      4'd4: begin eng_layer = 1'b1; eng_img = {88'b0, o1}; eng_filt = f2_q; end
      4'd5: begin eng_layer = 1'b1; eng_img = {88'b0, o2}; eng_filt = f3_q; end
      4'd6: begin eng_layer = 1'b1; eng_img = {88'b0, o2}; eng_filt = f4_q; end
      4'd7: begin eng_layer = 1'b1; eng_img = {88'b0, o3}; eng_filt = f2_q; end
      4'd8: begin eng_layer = 1'b1; eng_img = {88'b0, o3}; eng_filt = f2_q; end
      default: ;
    endcase
  end

  // Request capture, WAIT timeout counting, and result placement per job.
  // NOTE: the wide result/map registers are reset too, so nothing from an aborted job is ever visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_q    <= '0;
      f1_q     <= '0;
      f2_q     <= '0;
      f3_q     <= '0;
      f4_q     <= '0;
      o1       <= '0;
      o2       <= '0;
      o3       <= '0;
      out1     <= '0;
      out2     <= '0;
      job      <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        img_q <= in;
        f1_q  <= filter1;
        f2_q  <= filter2;
        f3_q  <= filter3;
        f4_q  <= filter4;
        err   <= 1'b0;
        job   <= '0;
      end
      if (state == ISSUE) wait_cnt <= '0;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (job_end) begin
          if (timed_out) err <= 1'b1;
          if (job != LAST_JOB) job <= job + 4'd1;
          case (job)
            4'd0: o1 <= res1;
            4'd1: o2 <= res1;
            4'd2: o3 <= res1;
            4'd3: out1[127:0]   <= res2;
            4'd4: out2[127:0]   <= res2;
            4'd5: out1[255:128] <= res2;
            4'd6: out2[255:128] <= res2;
            4'd7: begin
              out1[383:256] <= res2;
`ifdef NN_SCHED_SKIP_DUP_EN
              out2[383:256] <= res2;
`endif
            end
            4'd8: out2[383:256] <= res2;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/nn_conv_sched.md
NN_CONV_SCHED -- requirements
Module: nn_conv_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning max cycles waited for eng_done per job (1..255).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1 / in_ready output 1  job-request handshake.
REQ-005 SHALL have port in  input  288  12x12 image, 2 bits per pixel.
REQ-006 SHALL have ports filter1..filter4  input  18 each  3x3 kernels, 2 bits per tap.
REQ-007 SHALL have ports eng_start output 1, eng_layer output 1 (0 = 12x12 pass, 1 = 10x10 pass), eng_img output 288, eng_filt output 18  shared conv-engine command.
REQ-008 SHALL have ports eng_done input 1, eng_res1 input 200 (layer-1 map), eng_res2 input 128 (layer-2 map)  engine completion.
REQ-009 SHALL have ports out_valid output 1 / out_ready input 1, out1 output 384, out2 output 384  result handshake.
REQ-010 SHALL have ports busy output 1 (state != IDLE) and err output 1 (sticky timeout flag).

Function
REQ-011 SHALL time-multiplex one conv engine over the job table J0..J8 in fixed order.
REQ-012 Job table SHALL be: J0 in*f1->o1; J1 in*f3->o2; J2 in*f2->o3; J3 o1*f1->out1[127:0]; J4 o1*f2->out2[127:0]; J5 o2*f3->out1[255:128]; J6 o2*f4->out2[255:128]; J7 o3*f2->out1[383:256]; J8 o3*f2->out2[383:256].
REQ-013 SHALL hold o1..o3 in internal 200-bit registers; for layer-2 jobs eng_img SHALL be {88'b0, ok}.
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, OUT.
REQ-015 in_ready SHALL be 1 exactly in IDLE; on in_valid&&in_ready SHALL latch in and filter1..4, clear err, clear job index, and go to ISSUE.
REQ-016 ISSUE SHALL last one cycle with eng_start=1; eng_layer/eng_img/eng_filt SHALL be valid in ISSUE and held stable through WAIT.
REQ-017 WAIT SHALL capture eng_res1 (J0-J2) or eng_res2 (J3-J8) into the target slot on the edge where eng_done=1, then go to ISSUE for the next job, or to OUT after the last job.
REQ-018 eng_done SHALL be ignored outside WAIT.
REQ-019 Per-job cost SHALL be 1+L cycles, with L = cycles from eng_start to eng_done (L>=1); out_valid SHALL rise the cycle after the last capture.
REQ-020 WAIT SHALL count cycles; at TIMEOUT_CYC without eng_done it SHALL set err, write zero to the target slot, and advance as if eng_done had arrived.
REQ-021 OUT SHALL hold out_valid=1 with out1/out2 stable until out_ready=1, then return to IDLE; out1/out2 SHALL retain their values afterwards.
REQ-022 eng_done arriving on the same edge as the timeout SHALL be treated as done (result captured, err not set).
REQ-023 in_valid during non-IDLE states SHALL have no effect.

Reset
REQ-024 rst=1 SHALL force IDLE immediately: in_ready=1, busy=0, eng_start=0, out_valid=0, err=0; out1, out2, o1..o3, eng_img, eng_filt, eng_layer, job index and timeout counter SHALL be 0.
REQ-025 Reset mid-job SHALL abandon the job; a subsequent eng_done SHALL be ignored.

Configuration
REQ-026 Macro NN_SCHED_SKIP_DUP_EN defined: J8 SHALL NOT be issued; the J7 result SHALL be written to both out1[383:256] and out2[383:256], giving 8 engine passes.
REQ-027 Macro NN_SCHED_SKIP_DUP_EN undefined: all 9 jobs SHALL be issued.

Verification
REQ-028 Engine model with L=3, all filters 18'h00001, one request -> 9 eng_start pulses (8 with macro), out_valid at cycle 1+9*4 after accept (1+8*4 with macro).
REQ-029 out_ready held 0 for 10 cycles in OUT -> out_valid stays 1, outputs stable, in_ready stays 0; out_ready=1 -> IDLE next cycle.
REQ-030 eng_done never asserted for J4, TIMEOUT_CYC=8 -> err=1, out2[127:0]=0, remaining jobs complete normally; next accept clears err.
REQ-031 eng_done on the exact timeout cycle for J1 -> err=0, o2 holds eng_res1 value.
REQ-032 rst pulse during WAIT of J5 -> all outputs 0 and in_ready=1 immediately; stray eng_done ignored; a fresh request completes normally.
REQ-033 in_valid held 1 through a run with a changing input image -> only the accepted image is used; second request accepted only once back in IDLE.
